// File: rtl/audio_sample_framer.sv
//-----------------------------------------------------------------------------
// Module   : audio_sample_framer
// Purpose  : Captures one ADC sample per advance strobe, reduces it to mono
//            (left, right or floor-average), and packs the result into
//            ping-pong frames of FRAME_LEN samples for a downstream consumer.
//            Also drives the DAC with a one-sample-delayed loopback or silence.
// Ports    : CLOCK_50/reset_n       - clock, async active-low reset
//            advance                - one-cycle sample strobe
//            adc_left/adc_right     - ADC samples (valid with advance)
//            dac_left/dac_right     - registered DAC samples
//            loopback, chan_sel     - DAC source / mono select
//            frame_ready/frame_bank - frame handoff pulse / consumer bank
//            rd_addr/rd_data        - consumer read port (1-cycle latency)
//            frame_done             - consumer releases its bank
//            overrun_cnt            - saturating dropped-sample count
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module audio_sample_framer #(
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_W  = 24
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         advance,
  input  logic [SAMPLE_W-1:0]          adc_left,
  input  logic [SAMPLE_W-1:0]          adc_right,
  output logic [SAMPLE_W-1:0]          dac_left,
  output logic [SAMPLE_W-1:0]          dac_right,
  input  logic                         loopback,
  input  logic [1:0]                   chan_sel,
  output logic                         frame_ready,
  output logic                         frame_bank,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]          rd_data,
  input  logic                         frame_done,
  output logic [15:0]                  overrun_cnt
);

  localparam int AW = $clog2(FRAME_LEN);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         w_next_ptr;
  logic                  r_held;
  logic                  w_next_held;
  logic                  r_wr_bank;
  logic                  r_frame_ready;
  logic [15:0]           r_overrun;
  logic [SAMPLE_W-1:0]   r_dac_l;
  logic [SAMPLE_W-1:0]   r_dac_r;
  logic [SAMPLE_W-1:0]   r_rd_data;
  logic [SAMPLE_W-1:0]   r_mem [2*FRAME_LEN];

  logic                  w_swap;
  logic                  w_write;
  logic                  w_drop;
  logic                  w_last;
  logic [SAMPLE_W:0]     w_sum;
  logic [SAMPLE_W-1:0]   w_sample;

  // Sum in SAMPLE_W+1 bits so the average never overflows; dropping the LSB
  // of the two's-complement sum is an arithmetic shift (floor).
  assign w_sum = {adc_left[SAMPLE_W-1], adc_left} + {adc_right[SAMPLE_W-1], adc_right};

  always_comb begin
    case (chan_sel)
      2'd0:    w_sample = adc_left;
      2'd1:    w_sample = adc_right;
      default: w_sample = w_sum[SAMPLE_W:1];
    endcase
  end

  assign w_last = (r_wr_ptr == AW'(FRAME_LEN - 1));

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_wr_ptr;
    w_next_held  = r_held;
    w_swap       = 1'b0;
    w_write      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_FILL: begin
        if (frame_done) begin
          w_next_held = 1'b0;
        end
        if (advance) begin
          w_write = 1'b1;
          if (w_last) begin
            w_next_ptr = '0;
            // A release arriving with the last sample frees the consumer
            // bank in time, so the handoff happens without stalling.
            if (!r_held || frame_done) begin
              w_swap = 1'b1;
            end else begin
              w_next_state = S_WAIT;
            end
          end else begin
            w_next_ptr = r_wr_ptr + AW'(1);
          end
        end
      end
      S_WAIT: begin
        // Write bank is full: every sample here is lost, even one that
        // coincides with the releasing frame_done.
        w_drop = advance;
        if (frame_done) begin
          w_swap       = 1'b1;
          w_next_state = S_FILL;
        end
      end
      default: w_next_state = S_FILL;
    endcase
    if (w_swap) begin
      w_next_held = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FILL;
      r_wr_ptr      <= '0;
      r_held        <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_overrun     <= '0;
      r_dac_l       <= '0;
      r_dac_r       <= '0;
      r_rd_data     <= '0;
    end else begin
      r_state       <= w_next_state;
      r_wr_ptr      <= w_next_ptr;
      r_held        <= w_next_held;
      r_frame_ready <= w_swap;
      if (w_swap) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop && (r_overrun != 16'hFFFF)) begin
        r_overrun <= r_overrun + 16'd1;
      end
      if (advance) begin
        r_dac_l <= loopback ? adc_left  : '0;
        r_dac_r <= loopback ? adc_right : '0;
      end
      r_rd_data <= r_mem[{~r_wr_bank, rd_addr}];
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge CLOCK_50) begin
    if (w_write) begin
      r_mem[{r_wr_bank, r_wr_ptr}] <= w_sample;
    end
  end

  // The consumer bank is always the one not being written.
  assign frame_bank  = ~r_wr_bank;
  assign frame_ready = r_frame_ready;
  assign overrun_cnt = r_overrun;
  assign dac_left    = r_dac_l;
  assign dac_right   = r_dac_r;
  assign rd_data     = r_rd_data;

endmodule

`default_nettype wire

// File: doc/audio_sample_framer.md
# audio_sample_framer

Consumer-side partner of the 48 kHz audio driver. It captures one sample per `advance` pulse from the CODEC's ADC outputs and selects or mixes the channels to mono. Samples are packed into ping-pong frames of `FRAME_LEN` for the downstream FFT/fingerprint stage. The block also supplies the DAC inputs, which carry either a one-sample-delayed loopback or silence.

## Interface
- `FRAME_LEN`, 256: samples per frame; power of two, ≥ 4.
- `SAMPLE_W`, 24: sample width; two's complement.
- `CLOCK_50`  in  1: system clock, 50 MHz.
- `reset_n`  in  1: asynchronous, active-low reset.
- `advance`  in  1: one-cycle sample strobe from the audio driver.
- `adc_left`, `adc_right`  in  SAMPLE_W: ADC samples; valid in the `advance` cycle.
- `dac_left`, `dac_right`  out  SAMPLE_W: DAC samples; sampled by the driver in the `advance` cycle.
- `loopback`  in  1: 1 = DAC plays the captured input; 0 = DAC outputs zero.
- `chan_sel`  in  2: 0 = left, 1 = right, 2/3 = average of L and R.
- `frame_ready`  out  1: one-cycle pulse when a full frame is handed to the consumer.
- `frame_bank`  out  1: index of the bank currently owned by the consumer.
- `rd_addr`  in  log2(FRAME_LEN): consumer read address.
- `rd_data`  out  SAMPLE_W: sample at `rd_addr` of the consumer bank; 1-cycle latency.
- `frame_done`  in  1: one-cycle pulse; the consumer releases its bank.
- `overrun_cnt`  out  16: count of dropped samples; saturates at 0xFFFF.

## Operation
- Storage is two banks of FRAME_LEN × SAMPLE_W: one write bank (`wr_bank`) and one consumer bank (`frame_bank`), plus a `held` flag.
- **Sample select:**
  - `chan_sel` 0 selects L; 1 selects R.
  - 2/3 computes (L+R) sign-extended to SAMPLE_W+1 bits, then an arithmetic shift right by 1 (floor), then truncated to SAMPLE_W bits.
- **FILL state:**
  - On `advance`, write the selected sample to `wr_bank[wr_ptr]` and increment `wr_ptr`.
  - On writing index FRAME_LEN-1 with `held`=0, or with `frame_done` in the same cycle: swap.
    - `frame_bank` ← `wr_bank`; `wr_bank` ← ~`wr_bank`; `held` ← 1; `wr_ptr` ← 0.
    - Pulse `frame_ready` the next cycle. Stay in FILL.
  - Otherwise, on writing index FRAME_LEN-1: `wr_ptr` ← 0 and go to WAIT.
- **WAIT state:** the write bank is full and the consumer still holds its bank.
  - Each `advance` drops its sample and increments `overrun_cnt` (saturating).
  - `frame_done` performs the swap, pulses `frame_ready`, and returns to FILL.
  - If `advance` and `frame_done` occur in the same cycle, the swap wins: the sample is dropped and counted.
- `frame_done` with `held`=0 is ignored; the only effect is `held` stays 0.
- In FILL, `frame_done` clears `held`.
- **Read port:** `rd_data` ← `mem[frame_bank][rd_addr]` every cycle, regardless of `held`. Contents are defined only while `held`=1.
- **DAC path:**
  - On each `advance`, the `dac_left`/`dac_right` registers load `adc_left`/`adc_right` if `loopback`=1, else 0.
  - Outputs therefore present the previous sample during the current `advance` cycle (one-sample delay).
  - `chan_sel` does not affect the DAC path.

## Timing
- **Reset values:**
  - `dac_left`/`dac_right` = 0; `frame_ready` = 0; `frame_bank` = 1; `overrun_cnt` = 0; `rd_data` = 0.
  - Internal: `wr_bank` = 0, `wr_ptr` = 0, `held` = 0, state FILL.
  - Memory contents are not reset.
- **Frame latency:** `frame_ready` rises on the cycle after the clock edge that writes sample FRAME_LEN-1, or after the edge that accepts `frame_done` in WAIT.
- `frame_bank` changes on the same edge that raises `frame_ready`.
- **Read latency:** `rd_addr` applied at edge N appears on `rd_data` after edge N+1.
- `advance` pulses are ≥ 1000 cycles apart. Correct behaviour requires at most one pulse per cycle; no back-to-back handling is required.
- Reset asserted mid-frame discards the partial frame and any held frame. The first `advance` after release writes index 0 of bank 0.

## Test plan
- **Basic fill:** FRAME_LEN=8, `chan_sel`=0, adc_left = 1..8 on 8 advances.
  - `frame_ready` pulses once, 1 cycle after the 8th advance; `frame_bank`=0.
  - Reading addresses 0..7 returns 1..7, 8 with 1-cycle latency.
- **Averaging:**
  - L=0x7FFFFF, R=0x000001 → 0x400000.
  - L=0xFFFFFF, R=0xFFFFFE → 0xFFFFFE (floor of -1.5).
- **Ping-pong with overrun:** no `frame_done`, 8+8+3 advances.
  - Second frame completes → WAIT; `overrun_cnt`=3.
  - A `frame_done` then yields `frame_ready` with `frame_bank`=1.
- **Simultaneous events:** `frame_done` and `advance` in the same cycle in WAIT.
  - Swap occurs; `overrun_cnt` +1; the next advance writes index 0 of bank 0.
- **Loopback:** `loopback`=1, advances with L = 0x123456 then 0x654321.
  - In the second advance cycle, `dac_left` = 0x123456.
  - `loopback`=0 → `dac_left` = 0 after the next advance.
- **Reset:** assert `reset_n` low mid-frame (5 of 8 samples written), then release.
  - All outputs return to reset values immediately (asynchronously).
  - The next 8 advances produce a frame in bank 0.
